// File: rtl/tick_gen_pkg.sv
// Shared constants, divisor presets and helpers for the tick generator bank.
// Divisor presets assume the 100 MHz board clock.
package tick_gen_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int CNT_W       = 27;
    localparam int DEFAULT_DIV = 100_000;

    localparam int DIV_1KHZ  = CLK_HZ / 1_000;
    localparam int DIV_100HZ = CLK_HZ / 100;
    localparam int DIV_10HZ  = CLK_HZ / 10;
    localparam int DIV_1HZ   = CLK_HZ;

    typedef struct packed {
        logic tick;
        logic clk_out;
        logic pend;
    } ch_stat_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One divider channel: counter, active/shadow divisor and registered tick/clk_out.
// Outputs lag the counter by one edge; a pending shadow blocks further writes until applied.
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int W       = CNT_W,
    parameter int RST_DIV = DEFAULT_DIV
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         i_sync,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_div,
    output ch_stat_t     o_stat
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_act_div;
    logic [W-1:0] r_shd_div;
    logic         r_pend;
    logic         r_tick;
    logic         r_clk_out;

    logic w_run;
    logic w_wrap;
    logic w_apply;

    assign w_run   = (r_act_div != '0);
    assign w_wrap  = w_run && (r_cnt == r_act_div - W'(1));
    // A new divisor only ever lands at a period boundary, a stopped channel, or a realign.
    assign w_apply = r_pend && (i_sync || !w_run || w_wrap);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_act_div <= W'(RST_DIV);
            r_shd_div <= W'(RST_DIV);
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            if (i_sync || !w_run) begin
                r_cnt     <= '0;
                r_tick    <= 1'b0;
                r_clk_out <= 1'b0;
            end else begin
                r_tick    <= w_wrap;
                r_clk_out <= (r_cnt >= (r_act_div >> 1));
                r_cnt     <= w_wrap ? '0 : r_cnt + W'(1);
            end
            if (w_apply) begin
                r_act_div <= r_shd_div;
                r_pend    <= 1'b0;
            end
            // Write after apply so a same-edge write stays pending behind the old shadow.
            if (i_wr_en) begin
                r_shd_div <= i_wr_div;
                r_pend    <= 1'b1;
            end
        end
    end

    assign o_stat.tick    = r_tick;
    assign o_stat.clk_out = r_clk_out;
    assign o_stat.pend    = r_pend;

endmodule

// File: rtl/tick_generator_bank.sv
// Bank of NUM_CH programmable clock-enable dividers with shared config port and sync.
// cfg_ready drops for a channel one cycle after accept and returns when its shadow applies.
module tick_generator_bank #(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = tick_gen_pkg::CNT_W,
    parameter int  DEFAULT_DIV = tick_gen_pkg::DEFAULT_DIV,
    localparam int CH_W        = (tick_gen_pkg::clog2(NUM_CH) > 1) ? tick_gen_pkg::clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    tick_gen_pkg::ch_stat_t w_stat [NUM_CH];
    logic [NUM_CH-1:0]      w_pend;
    logic [NUM_CH-1:0]      w_wr_en;

    // Out-of-range channel numbers read as ready so the write is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !w_pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_en[g] = cfg_valid && !w_pend[g] && (cfg_ch == CH_W'(g));

        tick_gen_channel #(
            .W       (CNT_W),
            .RST_DIV (DEFAULT_DIV)
        ) u_ch (
            .clkin    (clkin),
            .rst      (rst),
            .i_sync   (sync),
            .i_wr_en  (w_wr_en[g]),
            .i_wr_div (cfg_div),
            .o_stat   (w_stat[g])
        );

        assign w_pend[g]  = w_stat[g].pend;
        assign tick[g]    = w_stat[g].tick;
        assign clk_out[g] = w_stat[g].clk_out;
    end

endmodule

// File: tb/tb_tick_generator_bank.sv
// Bench for tick_generator_bank: vector table, directed corner sequences, random vs reference model.
module tb_tick_generator_bank;

    localparam int NCH  = 4;
    localparam int W    = 27;
    localparam int DDIV = 10;

    logic         clkin = 1'b0;
    logic         rst   = 1'b1;
    logic         sync  = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_ch  = '0;
    logic [W-1:0] cfg_div = '0;
    logic [3:0]   tick;
    logic [3:0]   clk_out;

    int checks   = 0;
    int failures = 0;

    tick_generator_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel remembers the edge number at which its current
    // period began; outputs follow from the elapsed edge count within the period.
    int         n;
    int         m_div   [NCH];
    int         m_shd   [NCH];
    int         m_start [NCH];
    bit         m_pend  [NCH];
    logic [3:0] m_tick;
    logic [3:0] m_clk;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i]   = DDIV;
            m_shd[i]   = DDIV;
            m_start[i] = 0;
            m_pend[i]  = 1'b0;
        end
        m_tick = '0;
        m_clk  = '0;
    endtask

    function automatic bit model_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_step(input bit s, input bit v, input int ch, input int d);
        bit acc;
        bit boundary;
        int e;
        acc = v && model_ready(ch) && (ch < NCH);
        n++;
        for (int i = 0; i < NCH; i++) begin
            e        = n - m_start[i];
            boundary = 1'b0;
            if (s || m_div[i] == 0) begin
                m_tick[i]  = 1'b0;
                m_clk[i]   = 1'b0;
                m_start[i] = n;
                boundary   = 1'b1;
            end else begin
                m_tick[i] = (e == m_div[i]);
                m_clk[i]  = (e > m_div[i] / 2);
                if (e == m_div[i]) begin
                    m_start[i] = n;
                    boundary   = 1'b1;
                end
            end
            if (boundary && m_pend[i]) begin
                m_div[i]  = m_shd[i];
                m_pend[i] = 1'b0;
            end
            if (acc && ch == i) begin
                m_shd[i]  = d;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
    endtask

    // Leaves time at a falling edge with reset just released; next rising edge is edge 1.
    task automatic do_reset();
        @(negedge clkin);
        rst = 1'b1;
        idle_inputs();
        @(negedge clkin);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         sy;
        bit         vl;
        int         ch;
        int         dv;
        logic [3:0] et;
        logic [3:0] ec;
        logic       er;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [3:0] exp_t;
        bit         sy;
        bit         vl;
        int         ch;
        int         dv;

        // Div 0 then div 1 on channel 3 while the others run at the reset divisor.
        tbl[0]  = '{1'b0, 1'b1, 3, 0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'hF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'hF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'hF, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3, 1, 4'h0, 4'hF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3, 1, 4'hF, 4'hF, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 3, 1, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 3, 1, 4'h0, 4'h0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 3, 1, 4'h8, 4'h8, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3, 1, 4'h8, 4'h8, 1'b1};

        rst = 1'b1;
        idle_inputs();
        @(negedge clkin);
        #1;
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'h1);
        @(negedge clkin);
        rst = 1'b0;

        for (int r = 0; r < 14; r++) begin
            sync      = tbl[r].sy;
            cfg_valid = tbl[r].vl;
            cfg_ch    = 2'(tbl[r].ch);
            cfg_div   = W'(tbl[r].dv);
            @(posedge clkin);
            #1;
            check($sformatf("tbl%0d_tick", r), 32'(tick), 32'(tbl[r].et));
            check($sformatf("tbl%0d_clk_out", r), 32'(clk_out), 32'(tbl[r].ec));
            check($sformatf("tbl%0d_cfg_ready", r), 32'(cfg_ready), 32'(tbl[r].er));
            @(negedge clkin);
        end

        // First ticks after reset land on edges 10, 20, 30 with a 5/5 square wave.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            @(posedge clkin);
            #1;
            check($sformatf("boot_tick_e%0d", k), 32'(tick[0]), 32'((k % 10) == 0));
            check($sformatf("boot_clk_e%0d", k), 32'(clk_out[0]), 32'(((k - 1) % 10) >= 5));
        end

        // Sync realignment with divisors 3/5/8/10 and a same-cycle write to channel 0.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cfg_valid = 1'b1;
            cfg_ch    = 2'(c);
            cfg_div   = (c == 0) ? W'(3) : (c == 1) ? W'(5) : W'(8);
            @(posedge clkin);
            #1;
            check($sformatf("sync_setup_pend_ch%0d", c), 32'(cfg_ready), 32'h0);
            @(negedge clkin);
        end
        idle_inputs();
        repeat (11) @(posedge clkin);
        @(negedge clkin);
        sync      = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = W'(6);
        @(posedge clkin);
        #1;
        check("sync_edge_tick", 32'(tick), 32'h0);
        check("sync_edge_clk_out", 32'(clk_out), 32'h0);
        check("sync_edge_write_pend", 32'(cfg_ready), 32'h0);
        @(negedge clkin);
        idle_inputs();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clkin);
            #1;
            exp_t = {k == 10, k == 8, (k == 5) || (k == 10), (k == 3) || (k == 9)};
            check($sformatf("sync_k%0d_tick", k), 32'(tick), 32'(exp_t));
            check($sformatf("sync_k%0d_ready", k), 32'(cfg_ready), 32'(k >= 3));
        end

        // Reset pulsed between edges mid-count drops outputs at once and loses pending writes.
        do_reset();
        repeat (7) @(posedge clkin);
        @(negedge clkin);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = W'(4);
        @(posedge clkin);
        @(negedge clkin);
        cfg_valid = 1'b0;
        #1;
        check("pre_rst_pend", 32'(cfg_ready), 32'h0);
        check("pre_rst_clk_out", 32'(clk_out), 32'hF);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_clk_out", 32'(clk_out), 32'h0);
        check("mid_rst_ready", 32'(cfg_ready), 32'h1);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clkin);
            #1;
            check($sformatf("post_rst_k%0d_tick", k), 32'(tick), (k == 10) ? 32'hF : 32'h0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int it = 0; it < 1500; it++) begin
            sy = ($urandom_range(0, 39) == 0);
            vl = ($urandom_range(0, 3) == 0);
            ch = int'($urandom_range(0, 3));
            dv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
            sync      = sy;
            cfg_valid = vl;
            cfg_ch    = 2'(ch);
            cfg_div   = W'(dv);
            #1;
            check($sformatf("rnd%0d_ready", it), 32'(cfg_ready), 32'(model_ready(ch)));
            @(posedge clkin);
            #1;
            model_step(sy, vl, ch, dv);
            check($sformatf("rnd%0d_tick", it), 32'(tick), 32'(m_tick));
            check($sformatf("rnd%0d_clk_out", it), 32'(clk_out), 32'(m_clk));
            @(negedge clkin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
